// File: rtl/vga_timing_pkg.sv
// Raster timing presets and helpers shared by the VGA timing generator.
package vga_timing_pkg;

  // Sum of the four segments of one raster dimension.
  function automatic int raster_total(input int disp, input int fp, input int sync, input int bp);
    return disp + fp + sync + bp;
  endfunction

  // 640x480 @ 60 Hz, VESA (both syncs active-low)
  localparam int VGA640_H_DISP  = 640;
  localparam int VGA640_H_FP    = 16;
  localparam int VGA640_H_SYNC  = 96;
  localparam int VGA640_H_BP    = 48;
  localparam int VGA640_V_DISP  = 480;
  localparam int VGA640_V_FP    = 10;
  localparam int VGA640_V_SYNC  = 2;
  localparam int VGA640_V_BP    = 33;
  localparam bit VGA640_HS_POL  = 1'b0;
  localparam bit VGA640_VS_POL  = 1'b0;
  localparam int VGA640_H_TOT   = VGA640_H_DISP + VGA640_H_FP + VGA640_H_SYNC + VGA640_H_BP;
  localparam int VGA640_V_TOT   = VGA640_V_DISP + VGA640_V_FP + VGA640_V_SYNC + VGA640_V_BP;

  // 800x600 @ 60 Hz, VESA (both syncs active-high)
  localparam int SVGA800_H_DISP = 800;
  localparam int SVGA800_H_FP   = 40;
  localparam int SVGA800_H_SYNC = 128;
  localparam int SVGA800_H_BP   = 88;
  localparam int SVGA800_V_DISP = 600;
  localparam int SVGA800_V_FP   = 1;
  localparam int SVGA800_V_SYNC = 4;
  localparam int SVGA800_V_BP   = 23;
  localparam bit SVGA800_HS_POL = 1'b1;
  localparam bit SVGA800_VS_POL = 1'b1;
  localparam int SVGA800_H_TOT  = SVGA800_H_DISP + SVGA800_H_FP + SVGA800_H_SYNC + SVGA800_H_BP;
  localparam int SVGA800_V_TOT  = SVGA800_V_DISP + SVGA800_V_FP + SVGA800_V_SYNC + SVGA800_V_BP;

endpackage

// File: rtl/pix_tick_div.sv
// Pixel-clock enable: one clk-wide p_tick every PIX_DIV enabled clk cycles.
module pix_tick_div #(
  parameter int PIX_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic p_tick
);

  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(PIX_DIV - 1);

  logic [DW-1:0] div_q;

  // Mod-PIX_DIV divider; holds while paused, cleared by restart.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
    end else if (restart) begin
      div_q <= '0;
    end else if (en) begin
      div_q <= (div_q == LAST) ? '0 : div_q + DW'(1);
    end
  end

  // Gated by reset so that with PIX_DIV=1 no tick leaks out while held in reset;
  // gated by restart so the pixel being discarded is never consumed downstream.
  assign p_tick = reset & en & ~restart & (div_q == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: sync, video window, coordinates, markers.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISP  = VGA640_H_DISP,
  parameter int H_FP    = VGA640_H_FP,
  parameter int H_SYNC  = VGA640_H_SYNC,
  parameter int H_BP    = VGA640_H_BP,
  parameter int V_DISP  = VGA640_V_DISP,
  parameter int V_FP    = VGA640_V_FP,
  parameter int V_SYNC  = VGA640_V_SYNC,
  parameter int V_BP    = VGA640_V_BP,
  parameter bit HS_POL  = 1'b1,
  parameter bit VS_POL  = 1'b1,
  parameter int PIX_DIV = 2,
  parameter int CW      = 10,
  parameter int FCW     = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           restart,
  output logic           hsync,
  output logic           vsync,
  output logic           video_on,
  output logic           p_tick,
  output logic [CW-1:0]  pixel_x,
  output logic [CW-1:0]  pixel_y,
  output logic           line_end,
  output logic           frame_start,
  output logic [FCW-1:0] frame_count
);

  localparam int H_TOT    = raster_total(H_DISP, H_FP, H_SYNC, H_BP);
  localparam int V_TOT    = raster_total(V_DISP, V_FP, V_SYNC, V_BP);
  localparam int HS_START = H_DISP + H_FP;
  localparam int HS_END   = H_DISP + H_FP + H_SYNC - 1;
  localparam int VS_START = V_DISP + V_FP;
  localparam int VS_END   = V_DISP + V_FP + V_SYNC - 1;

  if (H_TOT > (2 ** CW)) begin : g_bad_h_tot
    $error("vga_timing_gen: H_TOT=%0d does not fit in CW=%0d bits", H_TOT, CW);
  end
  if (V_TOT > (2 ** CW)) begin : g_bad_v_tot
    $error("vga_timing_gen: V_TOT=%0d does not fit in CW=%0d bits", V_TOT, CW);
  end
  if (PIX_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: PIX_DIV=%0d must be at least 1", PIX_DIV);
  end

  logic [CW-1:0]  h_q, v_q, h_nxt, v_nxt;
  logic [FCW-1:0] fc_q;
  logic           h_last, v_last;
  logic           hs_q, vs_q, vo_q;
  logic           hs_act_nxt, vs_act_nxt, vo_nxt;

  pix_tick_div #(.PIX_DIV(PIX_DIV)) u_div (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .restart (restart),
    .p_tick  (p_tick)
  );

  assign h_last = (h_q == CW'(H_TOT - 1));
  assign v_last = (v_q == CW'(V_TOT - 1));

  // Next raster position; the registered outputs are derived from it so they
  // land on the same edge as the coordinates they describe.
  always_comb begin
    h_nxt = h_q;
    v_nxt = v_q;
    if (restart) begin
      h_nxt = '0;
      v_nxt = '0;
    end else if (p_tick) begin
      h_nxt = h_last ? '0 : h_q + CW'(1);
      if (h_last) begin
        v_nxt = v_last ? '0 : v_q + CW'(1);
      end
    end
  end

  assign hs_act_nxt = (h_nxt >= CW'(HS_START)) && (h_nxt <= CW'(HS_END));
  assign vs_act_nxt = (v_nxt >= CW'(VS_START)) && (v_nxt <= CW'(VS_END));
  assign vo_nxt     = (h_nxt < CW'(H_DISP)) && (v_nxt < CW'(V_DISP));

  // Coordinate counters and completed-frame counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_q  <= '0;
      v_q  <= '0;
      fc_q <= '0;
    end else begin
      h_q <= h_nxt;
      v_q <= v_nxt;
      if (p_tick && h_last && v_last) begin
        fc_q <= fc_q + FCW'(1);
      end
    end
  end

  // Glitch-free sync and video window, zero skew against pixel_x/pixel_y.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      vo_q <= 1'b0;
    end else begin
      hs_q <= hs_act_nxt ? HS_POL : ~HS_POL;
      vs_q <= vs_act_nxt ? VS_POL : ~VS_POL;
      vo_q <= vo_nxt;
    end
  end

  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign video_on    = vo_q;
  assign pixel_x     = h_q;
  assign pixel_y     = v_q;
  assign frame_count = fc_q;
  assign line_end    = p_tick & h_last;
  assign frame_start = p_tick & (h_q == '0) & (v_q == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 geometry, 800x600 active-low variant, and a
// tiny raster for whole-frame, restart and frame-counter wrap scenarios.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // default-parameter instance
  logic d_rst = 1'b0, d_en = 1'b0, d_rs = 1'b0;
  logic d_hs, d_vs, d_vo, d_pt, d_le, d_fs;
  logic [9:0] d_x, d_y;
  logic [15:0] d_fc;

  vga_timing_gen u_def (
    .clk(clk), .reset(d_rst), .en(d_en), .restart(d_rs),
    .hsync(d_hs), .vsync(d_vs), .video_on(d_vo), .p_tick(d_pt),
    .pixel_x(d_x), .pixel_y(d_y), .line_end(d_le), .frame_start(d_fs),
    .frame_count(d_fc)
  );

  // 800x600, PIX_DIV=1, active-low syncs
  logic s_rst = 1'b0, s_en = 1'b0, s_rs = 1'b0;
  logic s_hs, s_vs, s_vo, s_pt, s_le, s_fs;
  logic [10:0] s_x, s_y;
  logic [15:0] s_fc;

  vga_timing_gen #(
    .H_DISP(SVGA800_H_DISP), .H_FP(SVGA800_H_FP), .H_SYNC(SVGA800_H_SYNC), .H_BP(SVGA800_H_BP),
    .V_DISP(SVGA800_V_DISP), .V_FP(SVGA800_V_FP), .V_SYNC(SVGA800_V_SYNC), .V_BP(SVGA800_V_BP),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIX_DIV(1), .CW(11), .FCW(16)
  ) u_svga (
    .clk(clk), .reset(s_rst), .en(s_en), .restart(s_rs),
    .hsync(s_hs), .vsync(s_vs), .video_on(s_vo), .p_tick(s_pt),
    .pixel_x(s_x), .pixel_y(s_y), .line_end(s_le), .frame_start(s_fs),
    .frame_count(s_fc)
  );

  // tiny raster: H 8/2/3/2 (H_TOT=15), V 4/1/2/1 (V_TOT=8), hs high, vs low
  logic m_rst = 1'b0, m_en = 1'b0, m_rs = 1'b0;
  logic m_hs, m_vs, m_vo, m_pt, m_le, m_fs;
  logic [3:0] m_x, m_y;
  logic [2:0] m_fc;

  vga_timing_gen #(
    .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .PIX_DIV(2), .CW(4), .FCW(3)
  ) u_sm (
    .clk(clk), .reset(m_rst), .en(m_en), .restart(m_rs),
    .hsync(m_hs), .vsync(m_vs), .video_on(m_vo), .p_tick(m_pt),
    .pixel_x(m_x), .pixel_y(m_y), .line_end(m_le), .frame_start(m_fs),
    .frame_count(m_fc)
  );

  task automatic test_reset;
    d_en = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({d_x, d_y, d_fc} !== 36'd0) begin
      n_err++; $display("FAIL reset_counts got x=%0d y=%0d fc=%0d required 0/0/0", d_x, d_y, d_fc);
    end
    n_cmp++;
    if ({d_hs, d_vs, d_vo} !== 3'b000) begin
      n_err++; $display("FAIL reset_levels got hs/vs/vo=%b%b%b required 000", d_hs, d_vs, d_vo);
    end
    n_cmp++;
    if ({d_pt, d_le, d_fs} !== 3'b000) begin
      n_err++; $display("FAIL reset_pulses got pt/le/fs=%b%b%b required 000", d_pt, d_le, d_fs);
    end
    d_rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({d_x, d_y, d_vo, d_pt, d_fs} !== {10'd0, 10'd0, 3'b111}) begin
      n_err++; $display("FAIL first_clk got x=%0d y=%0d vo=%b pt=%b fs=%b required 0 0 1 1 1",
                        d_x, d_y, d_vo, d_pt, d_fs);
    end
  endtask

  task automatic test_h_scan;
    int p, ex, ey, le_cnt, fs_cnt;
    bit ept, ehs, evo, ele, efs;
    logic [25:0] exp_v;
    le_cnt = 0; fs_cnt = 0;
    for (int k = 2; k <= 1604; k++) begin
      @(negedge clk);
      p = k / 2; ex = p % 800; ey = (p / 800) % 525;
      ept = (k % 2) == 1;
      ehs = (ex >= 656) && (ex <= 751);
      evo = (ex < 640) && (ey < 480);
      ele = ept && (ex == 799);
      efs = ept && (ex == 0) && (ey == 0);
      exp_v = {10'(ex), 10'(ey), ehs, 1'b0, evo, ept, ele, efs};
      n_cmp++;
      if ({d_x, d_y, d_hs, d_vs, d_vo, d_pt, d_le, d_fs} !== exp_v) begin
        n_err++; $display("FAIL h_scan k=%0d got %h required %h", k,
                          {d_x, d_y, d_hs, d_vs, d_vo, d_pt, d_le, d_fs}, exp_v);
      end
      if (ex == 639 && ept) begin
        n_cmp++;
        if (d_vo !== 1'b1) begin n_err++; $display("FAIL vo_x639 got %b required 1", d_vo); end
      end
      if (ex == 640 && !ept) begin
        n_cmp++;
        if (d_vo !== 1'b0) begin n_err++; $display("FAIL vo_x640 got %b required 0", d_vo); end
      end
      if (d_le === 1'b1) le_cnt++;
      if (d_fs === 1'b1) fs_cnt++;
    end
    n_cmp++;
    if (le_cnt != 1) begin n_err++; $display("FAIL line_end_count got %0d required 1", le_cnt); end
    n_cmp++;
    if (fs_cnt != 0) begin n_err++; $display("FAIL frame_start_count got %0d required 0", fs_cnt); end
  endtask

  task automatic test_pause;
    int guard;
    guard = 0;
    while (d_x !== 10'd300 && guard < 1000) begin @(negedge clk); guard++; end
    n_cmp++;
    if (d_x !== 10'd300) begin n_err++; $display("FAIL pause_reach got x=%0d required 300", d_x); end
    n_cmp++;
    if ({d_hs, d_vo, d_y} !== {1'b0, 1'b1, 10'd1}) begin
      n_err++; $display("FAIL pause_pre got hs=%b vo=%b y=%0d required 0 1 1", d_hs, d_vo, d_y);
    end
    d_en = 1'b0;
    for (int i = 0; i < 37; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({d_x, d_y, d_pt, d_hs, d_vo} !== {10'd300, 10'd1, 1'b0, 1'b0, 1'b1}) begin
        n_err++; $display("FAIL pause_hold i=%0d got x=%0d y=%0d pt=%b hs=%b vo=%b required 300 1 0 0 1",
                          i, d_x, d_y, d_pt, d_hs, d_vo);
      end
    end
    d_en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({d_pt, d_x} !== {1'b1, 10'd300}) begin
      n_err++; $display("FAIL resume_tick got pt=%b x=%0d required 1 300", d_pt, d_x);
    end
    @(negedge clk);
    n_cmp++;
    if (d_x !== 10'd301) begin n_err++; $display("FAIL resume_x got %0d required 301", d_x); end
  endtask

  task automatic test_async_reset;
    int guard;
    guard = 0;
    while (d_x !== 10'd655 && guard < 1000) begin @(negedge clk); guard++; end
    n_cmp++;
    if ({d_x, d_hs} !== {10'd655, 1'b0}) begin
      n_err++; $display("FAIL areset_reach got x=%0d hs=%b required 655 0", d_x, d_hs);
    end
    #2 d_rst = 1'b0;
    #1;
    n_cmp++;
    if ({d_x, d_y, d_fc, d_hs, d_vs, d_vo, d_pt, d_le, d_fs} !== 42'd0) begin
      n_err++; $display("FAIL areset_now got x=%0d y=%0d fc=%0d hs/vs/vo/pt/le/fs=%b%b%b%b%b%b required all 0",
                        d_x, d_y, d_fc, d_hs, d_vs, d_vo, d_pt, d_le, d_fs);
    end
    @(negedge clk);
    d_rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({d_x, d_y, d_fc, d_vo, d_pt, d_fs} !== {10'd0, 10'd0, 16'd0, 3'b111}) begin
      n_err++; $display("FAIL areset_restart got x=%0d y=%0d fc=%0d vo=%b pt=%b fs=%b required 0 0 0 1 1 1",
                        d_x, d_y, d_fc, d_vo, d_pt, d_fs);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (d_x !== 10'd2) begin n_err++; $display("FAIL areset_progress got x=%0d required 2", d_x); end
  endtask

  task automatic test_svga_timing;
    int ex, ey, hs_low;
    bit ehs, evo, ele;
    logic [27:0] exp_v;
    hs_low = 0;
    s_en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({s_hs, s_vs, s_pt} !== 3'b110) begin
      n_err++; $display("FAIL svga_reset got hs/vs/pt=%b%b%b required 110", s_hs, s_vs, s_pt);
    end
    s_rst = 1'b1;
    for (int k = 1; k <= 1060; k++) begin
      @(negedge clk);
      ex = k % 1056; ey = k / 1056;
      ehs = !((ex >= 840) && (ex <= 967));
      evo = ex < 800;
      ele = ex == 1055;
      exp_v = {11'(ex), 11'(ey), ehs, 1'b1, evo, 1'b1, ele, 1'b0};
      n_cmp++;
      if ({s_x, s_y, s_hs, s_vs, s_vo, s_pt, s_le, s_fs} !== exp_v) begin
        n_err++; $display("FAIL svga_scan k=%0d got %h required %h", k,
                          {s_x, s_y, s_hs, s_vs, s_vo, s_pt, s_le, s_fs}, exp_v);
      end
      if (ey == 0 && s_hs === 1'b0) hs_low++;
    end
    n_cmp++;
    if (hs_low != 128) begin n_err++; $display("FAIL svga_hs_width got %0d required 128", hs_low); end
  endtask

  task automatic check_sm(input int k, input int p, input int fc_base);
    int ex, ey;
    bit ept, ehs, evs, evo, ele, efs;
    logic [16:0] exp_v;
    ex = p % 15; ey = (p / 15) % 8;
    ept = (k % 2) == 1;
    ehs = (ex >= 10) && (ex <= 12);
    evs = !((ey == 5) || (ey == 6));
    evo = (ex < 8) && (ey < 4);
    ele = ept && (ex == 14);
    efs = ept && (ex == 0) && (ey == 0);
    exp_v = {4'(ex), 4'(ey), 3'((fc_base + p / 120) % 8), ehs, evs, evo, ept, ele, efs};
    n_cmp++;
    if ({m_x, m_y, m_fc, m_hs, m_vs, m_vo, m_pt, m_le, m_fs} !== exp_v) begin
      n_err++; $display("FAIL sm_scan k=%0d got %h required %h", k,
                        {m_x, m_y, m_fc, m_hs, m_vs, m_vo, m_pt, m_le, m_fs}, exp_v);
    end
  endtask

  task automatic test_sm_frames;
    m_en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({m_hs, m_vs, m_vo} !== 3'b010) begin
      n_err++; $display("FAIL sm_reset got hs/vs/vo=%b%b%b required 010", m_hs, m_vs, m_vo);
    end
    m_rst = 1'b1;
    for (int k = 1; k <= 480; k++) begin
      @(negedge clk);
      check_sm(k, k / 2, 0);
      if (k == 2 * (4 * 15)) begin
        n_cmp++;
        if (m_vo !== 1'b0) begin n_err++; $display("FAIL vo_y_disp got %b required 0", m_vo); end
      end
    end
    n_cmp++;
    if ({m_fc, m_x, m_y} !== {3'd2, 4'd0, 4'd0}) begin
      n_err++; $display("FAIL two_frames got fc=%0d x=%0d y=%0d required 2 0 0", m_fc, m_x, m_y);
    end
  endtask

  task automatic test_sm_restart;
    int guard;
    for (int k = 481; k <= 1284; k++) begin
      @(negedge clk);
      check_sm(k, k / 2, 0);
    end
    n_cmp++;
    if ({m_x, m_y, m_fc} !== {4'd12, 4'd2, 3'd5}) begin
      n_err++; $display("FAIL restart_pre got x=%0d y=%0d fc=%0d required 12 2 5", m_x, m_y, m_fc);
    end
    m_rs = 1'b1;
    @(negedge clk);
    m_rs = 1'b0;
    n_cmp++;
    if ({m_x, m_y, m_fc, m_vo, m_fs} !== {4'd0, 4'd0, 3'd5, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL restart_now got x=%0d y=%0d fc=%0d vo=%b fs=%b required 0 0 5 1 0",
                        m_x, m_y, m_fc, m_vo, m_fs);
    end
    @(negedge clk);
    n_cmp++;
    if ({m_pt, m_fs} !== 2'b11) begin
      n_err++; $display("FAIL restart_first_tick got pt=%b fs=%b required 1 1", m_pt, m_fs);
    end
    m_rs = 1'b1;
    #1;
    n_cmp++;
    if (m_fs !== 1'b0) begin n_err++; $display("FAIL restart_fs_suppress got %b required 0", m_fs); end
    @(negedge clk);
    m_rs = 1'b0;
    guard = 0;
    while (!(m_x === 4'd14 && m_pt === 1'b1) && guard < 40) begin @(negedge clk); guard++; end
    n_cmp++;
    if ({m_x, m_pt, m_le} !== {4'd14, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL restart_line_reach got x=%0d pt=%b le=%b required 14 1 1", m_x, m_pt, m_le);
    end
    m_rs = 1'b1;
    #1;
    n_cmp++;
    if (m_le !== 1'b0) begin n_err++; $display("FAIL restart_le_suppress got %b required 0", m_le); end
    @(negedge clk);
    m_rs = 1'b0;
    n_cmp++;
    if ({m_x, m_y, m_fc} !== {4'd0, 4'd0, 3'd5}) begin
      n_err++; $display("FAIL restart_line got x=%0d y=%0d fc=%0d required 0 0 5", m_x, m_y, m_fc);
    end
    guard = 0;
    while (m_x !== 4'd3 && guard < 20) begin @(negedge clk); guard++; end
    m_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (m_x !== 4'd3) begin n_err++; $display("FAIL paused_x got %0d required 3", m_x); end
    m_rs = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({m_x, m_y, m_fc, m_vo} !== {4'd0, 4'd0, 3'd5, 1'b1}) begin
      n_err++; $display("FAIL restart_paused got x=%0d y=%0d fc=%0d vo=%b required 0 0 5 1",
                        m_x, m_y, m_fc, m_vo);
    end
    m_rs = 1'b0;
    m_en = 1'b1;
  endtask

  task automatic test_sm_wrap;
    int guard;
    for (int k = 1; k <= 722; k++) begin
      @(negedge clk);
      check_sm(k, k / 2, 5);
      if (k == 720) begin
        n_cmp++;
        if (m_fc !== 3'd0) begin n_err++; $display("FAIL fc_wrap got %0d required 0", m_fc); end
      end
    end
    guard = 0;
    while (m_fc !== 3'd1 && guard < 400) begin @(negedge clk); guard++; end
    n_cmp++;
    if (m_fc !== 3'd1) begin n_err++; $display("FAIL fc_reach got %0d required 1", m_fc); end
    repeat (7) @(negedge clk);
    #2 m_rst = 1'b0;
    #1;
    n_cmp++;
    if ({m_x, m_y, m_fc, m_vs, m_vo} !== {4'd0, 4'd0, 3'd0, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL sm_areset got x=%0d y=%0d fc=%0d vs=%b vo=%b required 0 0 0 1 0",
                        m_x, m_y, m_fc, m_vs, m_vo);
    end
  endtask

  initial begin
    test_reset();
    test_h_scan();
    test_pause();
    test_async_reset();
    test_svga_timing();
    test_sm_frames();
    test_sm_restart();
    test_sm_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
